// File: rtl/video_pkg.sv
// Shared definitions for the video stream transmitter: FSM state encoding,
// pixel width, and helpers for sizing counters and computing frame period.
package video_pkg;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        VSYNC   = 3'd1,
        V_BACK  = 3'd2,
        LINE    = 3'd3,
        H_GAP   = 3'd4,
        V_FRONT = 3'd5
    } vid_state_e;

    // Bits needed to hold a count running 0..n-1 (at least 1 bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Cycles from the first post_vs high through the frame_done pulse, inclusive.
    function automatic int unsigned frame_period(input int unsigned vs_w,
                                                 input int unsigned v_bp,
                                                 input int unsigned img_w,
                                                 input int unsigned img_h,
                                                 input int unsigned h_blank,
                                                 input int unsigned v_fp);
        return vs_w + v_bp + img_h * (img_w + h_blank) + v_fp;
    endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Generic enabled up-counter that wraps to 0 after reaching its terminal value.
// Ports: clk, rst (sync, active-high), clr (sync clear), en (count enable),
//        last (terminal value), cnt (registered count).
module video_timing_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == last) ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/video_stream_tx.sv
// Frame-stream transmitter: walks a frame memory in raster order and emits a
// camera-style interface (vsync, line valid, pixel enable, 8-bit data) with
// programmable vertical and horizontal blanking.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   frame_en           start a frame whenever idle
//   pattern_sel        (only with VIDEO_STREAM_TX_TEST_PATTERN_EN) x+y test pattern
//   pix_rd_en/addr     frame memory read request (1-cycle read latency)
//   pix_rd_data        frame memory read data
//   post_vs/hs/clken   vsync, line valid, pixel enable
//   post_imgdata       pixel value, 0 outside active pixels
//   frame_done         one-cycle pulse at end of frame
//   frame_cnt          completed frame count
//   busy               frame in progress
// Optional feature macro: VIDEO_STREAM_TX_TEST_PATTERN_EN.
module video_stream_tx
    import video_pkg::*;
#(
    parameter int unsigned IMG_W   = 640,
    parameter int unsigned IMG_H   = 480,
    parameter int unsigned H_BLANK = 160,
    parameter int unsigned VS_W    = 4,
    parameter int unsigned V_BP    = 20,
    parameter int unsigned V_FP    = 10,
    parameter int unsigned ADDR_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_en,
`ifdef VIDEO_STREAM_TX_TEST_PATTERN_EN
    input  logic              pattern_sel,
`endif
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_rd_addr,
    input  logic [PIX_W-1:0]  pix_rd_data,
    output logic              post_vs,
    output logic              post_hs,
    output logic              post_clken,
    output logic [PIX_W-1:0]  post_imgdata,
    output logic              frame_done,
    output logic [15:0]       frame_cnt,
    output logic              busy
);

    localparam int unsigned DUR_MAX = max2(max2(VS_W, V_BP), max2(H_BLANK, V_FP));
    localparam int unsigned DUR_W   = cnt_w(DUR_MAX);
    localparam int unsigned X_W     = cnt_w(IMG_W);
    localparam int unsigned Y_W     = cnt_w(IMG_H);

    vid_state_e       state;
    vid_state_e       nxt;
    logic [DUR_W-1:0] dur_cnt;
    logic [DUR_W-1:0] dur_last;
    logic [X_W-1:0]   px_cnt;
    logic [Y_W-1:0]   ln_cnt;
    logic             dur_en;
    logic             dur_done;
    logic             line_end;
    logic             rd_req;
    logic [PIX_W-1:0] pix_src;

    // Terminal value of the blanking-duration counter for the current state.
    always_comb begin
        dur_last = '0;
        dur_en   = 1'b1;
        case (state)
            VSYNC:   dur_last = DUR_W'(VS_W - 1);
            V_BACK:  dur_last = DUR_W'(V_BP - 1);
            H_GAP:   dur_last = DUR_W'(H_BLANK - 1);
            V_FRONT: dur_last = DUR_W'(V_FP - 1);
            default: dur_en   = 1'b0;
        endcase
    end

    assign dur_done = dur_en && (dur_cnt == dur_last);
    assign line_end = (state == LINE) && (px_cnt == X_W'(IMG_W - 1));

    video_timing_cnt #(.W(DUR_W)) u_dur_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (dur_en),
        .last (dur_last),
        .cnt  (dur_cnt)
    );

    video_timing_cnt #(.W(X_W)) u_px_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (state == LINE),
        .last (X_W'(IMG_W - 1)),
        .cnt  (px_cnt)
    );

    video_timing_cnt #(.W(Y_W)) u_ln_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == IDLE),
        .en   (line_end),
        .last (Y_W'(IMG_H - 1)),
        .cnt  (ln_cnt)
    );

    // Next-state logic. The line counter wraps to 0 after the last line, so
    // a zero count seen during H_GAP means the frame's lines are exhausted.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (frame_en) nxt = VSYNC;
            VSYNC:   if (dur_done) nxt = V_BACK;
            V_BACK:  if (dur_done) nxt = LINE;
            LINE:    if (line_end) nxt = H_GAP;
            H_GAP:   if (dur_done) nxt = (ln_cnt == '0) ? V_FRONT : LINE;
            V_FRONT: if (dur_done) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Reads are issued one cycle ahead of LINE so the returning data lines up
    // with the registered LINE decode on post_hs/post_clken.
    assign rd_req = (nxt == LINE);

`ifdef VIDEO_STREAM_TX_TEST_PATTERN_EN
    logic             pat_q;
    logic [PIX_W-1:0] pat_pix;

    // Pattern select is latched at frame start and held for the whole frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= 1'b0;
        end else if (state == IDLE && frame_en) begin
            pat_q <= pattern_sel;
        end
    end

    assign pat_pix   = PIX_W'(px_cnt) + PIX_W'(ln_cnt);
    assign pix_src   = pat_q ? pat_pix : pix_rd_data;
    assign pix_rd_en = rd_req && !pat_q;
`else
    assign pix_src   = pix_rd_data;
    assign pix_rd_en = rd_req;
`endif

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pix_rd_addr  <= '0;
            post_vs      <= 1'b0;
            post_hs      <= 1'b0;
            post_clken   <= 1'b0;
            post_imgdata <= '0;
            frame_done   <= 1'b0;
            frame_cnt    <= '0;
            busy         <= 1'b0;
        end else begin
            state        <= nxt;
            post_vs      <= (state == VSYNC);
            post_hs      <= (state == LINE);
            post_clken   <= (state == LINE);
            post_imgdata <= (state == LINE) ? pix_src : '0;
            frame_done   <= (state == V_FRONT) && dur_done;
            busy         <= (nxt != IDLE);
            if (state == V_FRONT && dur_done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (state == IDLE) begin
                pix_rd_addr <= '0;
            end else if (rd_req) begin
                pix_rd_addr <= pix_rd_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_video_stream_tx.sv
// Directed bench for video_stream_tx on a 4x3 frame; memory returns addr+0x10.
module tb_video_stream_tx;
    import video_pkg::*;

    localparam int unsigned IMG_W   = 4;
    localparam int unsigned IMG_H   = 3;
    localparam int unsigned H_BLANK = 2;
    localparam int unsigned VS_W    = 3;
    localparam int unsigned V_BP    = 2;
    localparam int unsigned V_FP    = 2;
    localparam int unsigned ADDR_W  = 4;

    logic              clk;
    logic              rst;
    logic              frame_en;
    logic              pattern_sel;
    logic              pix_rd_en;
    logic [ADDR_W-1:0] pix_rd_addr;
    logic [7:0]        pix_rd_data;
    logic              post_vs;
    logic              post_hs;
    logic              post_clken;
    logic [7:0]        post_imgdata;
    logic              frame_done;
    logic [15:0]       frame_cnt;
    logic              busy;

    int tests = 0;
    int fails = 0;

    int   first_vs, vs_len, done_at, npix, overlap, blank_bad, nrd, first_addr, addr_bad;
    bit   timed_out;
    logic [7:0] pix [16];

    video_stream_tx #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .H_BLANK(H_BLANK),
        .VS_W(VS_W), .V_BP(V_BP), .V_FP(V_FP), .ADDR_W(ADDR_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_en     (frame_en),
`ifdef VIDEO_STREAM_TX_TEST_PATTERN_EN
        .pattern_sel  (pattern_sel),
`endif
        .pix_rd_en    (pix_rd_en),
        .pix_rd_addr  (pix_rd_addr),
        .pix_rd_data  (pix_rd_data),
        .post_vs      (post_vs),
        .post_hs      (post_hs),
        .post_clken   (post_clken),
        .post_imgdata (post_imgdata),
        .frame_done   (frame_done),
        .frame_cnt    (frame_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read frame memory, content = address + 0x10.
    always @(posedge clk) begin
        if (pix_rd_en) pix_rd_data <= 8'h10 + 8'(pix_rd_addr);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step one frame, recording interface activity until frame_done or a
    // cycle budget; frame_en is dropped once drop_pix pixels have appeared.
    task automatic capture(input int drop_pix);
        first_vs = -1; vs_len = 0; done_at = -1; npix = 0; overlap = 0;
        blank_bad = 0; nrd = 0; first_addr = -1; addr_bad = 0; timed_out = 1'b0;
        for (int i = 0; i < 16; i++) pix[i] = 8'h00;
        for (int s = 1; s <= 100 && done_at < 0; s++) begin
            @(negedge clk);
            if (post_vs) begin
                if (first_vs < 0) first_vs = s;
                vs_len++;
            end
            if (post_vs && post_hs) overlap++;
            if (post_hs !== post_clken) blank_bad++;
            if (!post_clken && post_imgdata !== 8'h00) blank_bad++;
            if (post_clken) begin
                if (npix < 16) pix[npix] = post_imgdata;
                npix++;
            end
            if (pix_rd_en) begin
                if (first_addr < 0) first_addr = int'(pix_rd_addr);
                if (pix_rd_addr !== ADDR_W'(nrd)) addr_bad++;
                nrd++;
            end
            if (frame_done) done_at = s;
            if (npix >= drop_pix) frame_en = 1'b0;
        end
        if (done_at < 0) timed_out = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int exp_cnt);
        check({tag, "_timeout"}, 32'(timed_out), 0);
        check({tag, "_vs_len"}, vs_len, 3);
        check({tag, "_npix"}, npix, 12);
        for (int i = 0; i < 12; i++)
            check($sformatf("%s_pix%0d", tag, i), 32'(pix[i]), 32'(8'h10 + 8'(i)));
        check({tag, "_period"}, done_at - first_vs + 1, 25);
        check({tag, "_vs_hs_overlap"}, overlap, 0);
        check({tag, "_blanking"}, blank_bad, 0);
        check({tag, "_addr_seq"}, addr_bad, 0);
        check({tag, "_first_addr"}, first_addr, 0);
        check({tag, "_nrd"}, nrd, 12);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), exp_cnt);
    endtask

    initial begin
        int hs;
        int vs_seen;
        rst = 1'b1; frame_en = 1'b0; pattern_sel = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_vs", 32'(post_vs), 0);
        check("rst_hs", 32'(post_hs), 0);
        check("rst_clken", 32'(post_clken), 0);
        check("rst_data", 32'(post_imgdata), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_cnt", 32'(frame_cnt), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_rd_en", 32'(pix_rd_en), 0);
        check("rst_addr", 32'(pix_rd_addr), 0);
        check("pkg_period", frame_period(VS_W, V_BP, IMG_W, IMG_H, H_BLANK, V_FP), 25);

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_busy", 32'(busy), 0);
        check("idle_rd_en", 32'(pix_rd_en), 0);

        // Single frame from a one-cycle frame_en pulse
        frame_en = 1'b1;
        capture(0);
        check_frame("f1", 1);
        check("f1_busy_end", 32'(busy), 0);
        vs_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (post_vs) vs_seen++;
        end
        check("f1_no_restart", vs_seen, 0);
        check("f1_busy_idle", 32'(busy), 0);

        // Continuous frame_en: back-to-back frames with one idle cycle
        frame_en = 1'b1;
        capture(1000);
        check_frame("f2", 2);
        capture(1000);
        check_frame("f3", 3);
        check("f3_gap_done_to_vs", first_vs, 2);

        // frame_en dropped during the first line: frame still completes
        capture(2);
        check_frame("f4", 4);
        check("f4_busy_end", 32'(busy), 0);
        vs_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (post_vs) vs_seen++;
        end
        check("f4_no_restart", vs_seen, 0);
        check("f4_busy_idle", 32'(busy), 0);

        // Reset during the second line aborts the frame
        frame_en = 1'b1;
        hs = 0;
        for (int s = 0; s < 100 && hs < 6; s++) begin
            @(negedge clk);
            if (post_hs) hs++;
        end
        check("abort_reached_line2", 32'(hs >= 6), 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_vs", 32'(post_vs), 0);
        check("abort_hs", 32'(post_hs), 0);
        check("abort_clken", 32'(post_clken), 0);
        check("abort_data", 32'(post_imgdata), 0);
        check("abort_done", 32'(frame_done), 0);
        check("abort_cnt", 32'(frame_cnt), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_rd_en", 32'(pix_rd_en), 0);
        check("abort_addr", 32'(pix_rd_addr), 0);
        rst = 1'b0;
        capture(12);
        check_frame("f5", 1);

`ifdef VIDEO_STREAM_TX_TEST_PATTERN_EN
        // Test pattern: data = x + y, no memory reads
        pattern_sel = 1'b1;
        frame_en    = 1'b1;
        capture(0);
        pattern_sel = 1'b0;
        check("pat_timeout", 32'(timed_out), 0);
        check("pat_npix", npix, 12);
        check("pat_nrd", nrd, 0);
        check("pat_pix0", 32'(pix[0]), 0);
        check("pat_pix7", 32'(pix[7]), 4);
        check("pat_l2_0", 32'(pix[8]), 2);
        check("pat_l2_1", 32'(pix[9]), 3);
        check("pat_l2_2", 32'(pix[10]), 4);
        check("pat_l2_3", 32'(pix[11]), 5);
        check("pat_frame_cnt", 32'(frame_cnt), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
